operand_fetch_stage: RTL



---
 rtl/ofs_pkg.sv | 40 ++++
 rtl/operand_fetch_stage_scoreboard.sv | 56 +++++
 rtl/operand_fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ofs_pkg.sv
// Shared types and defaults for the operand fetch stage: widths, register index,
// the uop carried in the output register, and the output-register state.
package ofs_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int NUM_REGS     = 32;
    localparam int NUM_REGS_LOG = $clog2(NUM_REGS);
    localparam int CTRL_WIDTH   = 32;

    typedef logic [NUM_REGS_LOG-1:0] reg_idx_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        reg_idx_t              rd;
        logic                  rd_wen;
        logic [CTRL_WIDTH-1:0] ctrl;
    } uop_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ofs_state_e;

    // x0 always reads zero; a same-cycle writeback overrides the register file.
    function automatic logic [DATA_WIDTH-1:0] select_operand(
        input reg_idx_t              rs,
        input logic                  wb_hit,
        input logic [DATA_WIDTH-1:0] wb_val,
        input logic [DATA_WIDTH-1:0] rf_val
    );
        if (rs == '0)
            return '0;
        else if (wb_hit)
            return wb_val;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared by writeback or by a flushed
// output entry. Lookups already discount a register retiring this cycle.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             kill_en,
    input  logic [IDX_W-1:0] kill_idx,
    input  logic [IDX_W-1:0] look_a,
    input  logic [IDX_W-1:0] look_b,
    input  logic [IDX_W-1:0] look_c,
    output logic             busy_a,
    output logic             busy_b,
    output logic             busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] eff_busy;

    always_comb begin
        clr_vec = '0;
        if (clr_en && clr_idx != '0)
            clr_vec[clr_idx] = 1'b1;
    end

    assign eff_busy = busy_q & ~clr_vec;
    assign busy_a   = eff_busy[look_a];
    assign busy_b   = eff_busy[look_b];
    assign busy_c   = eff_busy[look_c];

    // Set is applied last so a register re-issued in its retiring cycle stays busy.
    always_comb begin
        busy_d = eff_busy;
        if (kill_en)
            busy_d[kill_idx] = 1'b0;
        if (set_en)
            busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, stalls on RAW/WAW against the busy
// scoreboard, bypasses same-cycle writeback, and holds one uop for execute.
module operand_fetch_stage #(
    parameter int DATA_WIDTH   = ofs_pkg::DATA_WIDTH,
    parameter int NUM_REGS     = ofs_pkg::NUM_REGS,
    parameter int NUM_REGS_LOG = $clog2(NUM_REGS),
    parameter int CTRL_WIDTH   = ofs_pkg::CTRL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_REGS_LOG-1:0] in_rs1,
    input  logic [NUM_REGS_LOG-1:0] in_rs2,
    input  logic [NUM_REGS_LOG-1:0] in_rd,
    input  logic                    in_rs1_use,
    input  logic                    in_rs2_use,
    input  logic                    in_rd_wen,
    input  logic [DATA_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0]   in_imm,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,
    output logic [NUM_REGS_LOG-1:0] rf_read1,
    output logic [NUM_REGS_LOG-1:0] rf_read2,
    input  logic [DATA_WIDTH-1:0]   rf_data1,
    input  logic [DATA_WIDTH-1:0]   rf_data2,
    input  logic                    wb_valid,
    input  logic [NUM_REGS_LOG-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_rs1_val,
    output logic [DATA_WIDTH-1:0]   out_rs2_val,
    output logic [DATA_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0]   out_imm,
    output logic [NUM_REGS_LOG-1:0] out_rd,
    output logic                    out_rd_wen,
    output logic [CTRL_WIDTH-1:0]   out_ctrl
);

    import ofs_pkg::*;

    ofs_state_e            state_q, state_d;
    uop_t                  uop_q, uop_d;
    logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
    logic [DATA_WIDTH-1:0] rs2_val_q, rs2_val_d;

    logic busy_rs1, busy_rs2, busy_rd;
    logic wb_hit1, wb_hit2;
    logic hazard, accept;

    assign rf_read1 = in_rs1;
    assign rf_read2 = in_rs2;

    assign wb_hit1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
    assign wb_hit2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (NUM_REGS_LOG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (accept && in_rd_wen && (in_rd != '0)),
        .set_idx  (in_rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .kill_en  (flush && out_valid && uop_q.rd_wen),
        .kill_idx (uop_q.rd),
        .look_a   (in_rs1),
        .look_b   (in_rs2),
        .look_c   (in_rd),
        .busy_a   (busy_rs1),
        .busy_b   (busy_rs2),
        .busy_c   (busy_rd)
    );

    assign hazard = (in_rs1_use && busy_rs1)
                  || (in_rs2_use && busy_rs2)
                  || (in_rd_wen && busy_rd);

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (flush)
                    state_d = ST_EMPTY;
                else if (!accept && out_ready)
                    state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Data fields only move on accept; they hold through drain and flush.
    always_comb begin
        uop_d     = uop_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        if (accept) begin
            uop_d.pc     = in_pc;
            uop_d.imm    = in_imm;
            uop_d.rd     = in_rd;
            uop_d.rd_wen = in_rd_wen;
            uop_d.ctrl   = in_ctrl;
            rs1_val_d    = select_operand(in_rs1, wb_hit1, wb_data, rf_data1);
            rs2_val_d    = select_operand(in_rs2, wb_hit2, wb_data, rf_data2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            uop_q     <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
        end else begin
            state_q   <= state_d;
            uop_q     <= uop_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
        end
    end

    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_pc      = uop_q.pc;
    assign out_imm     = uop_q.imm;
    assign out_rd      = uop_q.rd;
    assign out_rd_wen  = uop_q.rd_wen;
    assign out_ctrl    = uop_q.ctrl;

endmodule
